// File: rtl/unidade_controle_pkg.sv
// Shared state codes, default timing constants and output decode for the memory-game control unit.
// The datapath debug decoder imports the same state codes.
package unidade_controle_pkg;

  localparam logic [3:0] EST_INICIAL        = 4'h0;
  localparam logic [3:0] EST_PREPARACAO     = 4'h1;
  localparam logic [3:0] EST_MOSTRA_INICIAL = 4'h2;
  localparam logic [3:0] EST_INICIO_RODADA  = 4'h3;
  localparam logic [3:0] EST_ESPERA_JOGADA  = 4'h4;
  localparam logic [3:0] EST_REGISTRA       = 4'h5;
  localparam logic [3:0] EST_COMPARA        = 4'h6;
  localparam logic [3:0] EST_PROXIMA_JOGADA = 4'h7;
  localparam logic [3:0] EST_NOVA_JOGADA    = 4'h8;
  localparam logic [3:0] EST_ESPERA_NOVA    = 4'h9;
  localparam logic [3:0] EST_REGISTRA_NOVA  = 4'hA;
  localparam logic [3:0] EST_GRAVA_NOVA     = 4'hB;
  localparam logic [3:0] EST_FIM_GANHOU     = 4'hC;
  localparam logic [3:0] EST_FIM_TIMEOUT    = 4'hD;
  localparam logic [3:0] EST_FIM_ERROU      = 4'hE;

  localparam int MOSTRA_CICLOS_PADRAO  = 2000;
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;

  typedef enum logic [3:0] {
    INICIAL        = EST_INICIAL,
    PREPARACAO     = EST_PREPARACAO,
    MOSTRA_INICIAL = EST_MOSTRA_INICIAL,
    INICIO_RODADA  = EST_INICIO_RODADA,
    ESPERA_JOGADA  = EST_ESPERA_JOGADA,
    REGISTRA       = EST_REGISTRA,
    COMPARA        = EST_COMPARA,
    PROXIMA_JOGADA = EST_PROXIMA_JOGADA,
    NOVA_JOGADA    = EST_NOVA_JOGADA,
    ESPERA_NOVA    = EST_ESPERA_NOVA,
    REGISTRA_NOVA  = EST_REGISTRA_NOVA,
    GRAVA_NOVA     = EST_GRAVA_NOVA,
    FIM_GANHOU     = EST_FIM_GANHOU,
    FIM_TIMEOUT    = EST_FIM_TIMEOUT,
    FIM_ERROU      = EST_FIM_ERROU
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraR;
    logic contaR;
    logic registraR;
    logic grava;
    logic acende_leds;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zeraE = 1'b1;
        s.zeraR = 1'b1;
      end
      MOSTRA_INICIAL: s.acende_leds = 1'b1;
      INICIO_RODADA:  s.zeraE       = 1'b1;
      REGISTRA:       s.registraR   = 1'b1;
      PROXIMA_JOGADA: s.contaE      = 1'b1;
      NOVA_JOGADA:    s.contaE      = 1'b1;
      REGISTRA_NOVA:  s.registraR   = 1'b1;
      GRAVA_NOVA: begin
        s.grava  = 1'b1;
        s.contaR = 1'b1;
      end
      FIM_GANHOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        s.pronto     = 1'b1;
        s.perdeu     = 1'b1;
        s.db_timeout = 1'b1;
      end
`endif
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_desafio_contador_m.sv
// Saturating modulo-M counter used for the LED-display and play-timeout timers.
module contador_m #(
  parameter int M = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  localparam int N = (M > 1) ? $clog2(M) : 1;
  localparam logic [N-1:0] TERMINAL = N'(M - 1);

  logic [N-1:0] r_q;

  // Holds at the terminal count instead of wrapping so the timer flag stays up
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_zera) begin
      r_q <= '0;
    end else if (i_conta && (r_q != TERMINAL)) begin
      r_q <= r_q + N'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign o_fim = (r_q == TERMINAL);

endmodule

// File: rtl/unidade_controle_desafio.sv
// Moore control unit for jogo_desafio_memoria; outputs are registered from the next state.
// Build macro TIMEOUT_EN adds the play-timeout timer and the fim_timeout state.
module unidade_controle_desafio
  import unidade_controle_pkg::*;
#(
  parameter int MOSTRA_CICLOS = MOSTRA_CICLOS_PADRAO
`ifdef TIMEOUT_EN
  , parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimR,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       registraR,
  output logic       grava,
  output logic       acende_leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t r_estado;
  estado_t w_prox;
  saidas_t r_saidas;
  logic    w_fim_mostra;
  logic    w_fim_timeout;
  logic    w_zera_timeout;
  logic    w_conta_timeout;

  contador_m #(.M(MOSTRA_CICLOS)) u_timer_mostra (
    .i_clock (clock),
    .i_reset (reset),
    .i_zera  (r_estado == PREPARACAO),
    .i_conta (r_estado == MOSTRA_INICIAL),
    .o_fim   (w_fim_mostra)
  );

  assign w_zera_timeout  = (r_estado == PREPARACAO) || (r_estado == INICIO_RODADA) ||
                           (r_estado == PROXIMA_JOGADA) || (r_estado == NOVA_JOGADA);
  assign w_conta_timeout = (r_estado == ESPERA_JOGADA) || (r_estado == ESPERA_NOVA);

`ifdef TIMEOUT_EN
  contador_m #(.M(TIMEOUT_CICLOS)) u_timer_timeout (
    .i_clock (clock),
    .i_reset (reset),
    .i_zera  (w_zera_timeout),
    .i_conta (w_conta_timeout),
    .o_fim   (w_fim_timeout)
  );
`else
  assign w_fim_timeout = 1'b0 & w_zera_timeout & w_conta_timeout;
`endif

  // Next-state logic; a play always wins over a simultaneous timeout
  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:        if (iniciar) w_prox = PREPARACAO; else w_prox = INICIAL;
      PREPARACAO:     w_prox = MOSTRA_INICIAL;
      MOSTRA_INICIAL: if (w_fim_mostra) w_prox = INICIO_RODADA; else w_prox = MOSTRA_INICIAL;
      INICIO_RODADA:  w_prox = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (tem_jogada)         w_prox = REGISTRA;
        else if (w_fim_timeout) w_prox = FIM_TIMEOUT;
        else                    w_prox = ESPERA_JOGADA;
      end
      REGISTRA:       w_prox = COMPARA;
      COMPARA: begin
        if (!jogada_correta)           w_prox = FIM_ERROU;
        else if (!enderecoIgualRodada) w_prox = PROXIMA_JOGADA;
        else if (fimR)                 w_prox = FIM_GANHOU;
        else                           w_prox = NOVA_JOGADA;
      end
      PROXIMA_JOGADA: w_prox = ESPERA_JOGADA;
      NOVA_JOGADA:    w_prox = ESPERA_NOVA;
      ESPERA_NOVA: begin
        if (tem_jogada)         w_prox = REGISTRA_NOVA;
        else if (w_fim_timeout) w_prox = FIM_TIMEOUT;
        else                    w_prox = ESPERA_NOVA;
      end
      REGISTRA_NOVA:  w_prox = GRAVA_NOVA;
      GRAVA_NOVA:     w_prox = INICIO_RODADA;
      FIM_GANHOU:     if (iniciar) w_prox = PREPARACAO; else w_prox = FIM_GANHOU;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT:    if (iniciar) w_prox = PREPARACAO; else w_prox = FIM_TIMEOUT;
`endif
      FIM_ERROU:      if (iniciar) w_prox = PREPARACAO; else w_prox = FIM_ERROU;
      default:        w_prox = INICIAL;
    endcase
  end

  // State register with output flops decoded from the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_saidas <= '0;
    end else begin
      r_estado <= w_prox;
      r_saidas <= decodifica_saidas(w_prox);
    end
  end

  assign zeraE       = r_saidas.zeraE;
  assign contaE      = r_saidas.contaE;
  assign zeraR       = r_saidas.zeraR;
  assign contaR      = r_saidas.contaR;
  assign registraR   = r_saidas.registraR;
  assign grava       = r_saidas.grava;
  assign acende_leds = r_saidas.acende_leds;
  assign pronto      = r_saidas.pronto;
  assign ganhou      = r_saidas.ganhou;
  assign perdeu      = r_saidas.perdeu;
  assign db_timeout  = r_saidas.db_timeout;
  assign db_estado   = r_estado;

endmodule

// File: tb/tb_unidade_controle_desafio.sv
// Scoreboard bench for unidade_controle_desafio; expectations follow the TIMEOUT_EN build macro.
module tb_unidade_controle_desafio;

  logic       clock = 1'b0;
  logic       reset, iniciar, tem_jogada, jogada_correta, enderecoIgualRodada, fimR;
  logic       zeraE, contaE, zeraR, contaR, registraR, grava, acende_leds;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;
  logic [10:0] w_saidas;

  int n_verif  = 0;
  int n_falhas = 0;

  typedef struct {
    logic [3:0]  estado;
    logic [10:0] saidas;
  } esp_t;
  esp_t fila[$];

  unidade_controle_desafio dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada), .fimR(fimR),
    .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR), .registraR(registraR),
    .grava(grava), .acende_leds(acende_leds), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign w_saidas = {zeraE, contaE, zeraR, contaR, registraR, grava, acende_leds,
                     pronto, ganhou, perdeu, db_timeout};

  // Bit order: zeraE contaE zeraR contaR registraR grava acende pronto ganhou perdeu db_timeout
  function automatic logic [10:0] saidas_esp(input logic [3:0] e);
    case (e)
      4'h1:       return 11'b10100000000;
      4'h2:       return 11'b00000010000;
      4'h3:       return 11'b10000000000;
      4'h5, 4'hA: return 11'b00001000000;
      4'h7, 4'h8: return 11'b01000000000;
      4'hB:       return 11'b00010100000;
      4'hC:       return 11'b00000001100;
      4'hD:       return 11'b00000001011;
      4'hE:       return 11'b00000001010;
      default:    return 11'b00000000000;
    endcase
  endfunction

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_verif++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic passo(input logic [3:0] e);
    esp_t x;
    x.estado = e;
    x.saidas = saidas_esp(e);
    fila.push_back(x);
    tick();
    x = fila.pop_front();
    verifica($sformatf("estado_%h", x.estado), {28'd0, db_estado}, {28'd0, x.estado});
    verifica($sformatf("saidas_%h", x.estado), {21'd0, w_saidas}, {21'd0, x.saidas});
  endtask

  task automatic inicia_jogo(input int n_iniciar);
    int cont;
    iniciar    = 1'b1;
    tem_jogada = 1'b1;
    passo(4'h1);
    for (int i = 1; i < n_iniciar; i++) passo(4'h2);
    iniciar    = 1'b0;
    tem_jogada = 1'b0;
    cont = n_iniciar - 1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (db_estado == 4'h2 && acende_leds) cont++;
      else break;
    end
    verifica("mostra_ciclos", cont, 2000);
    verifica("estado_3", {28'd0, db_estado}, 32'h3);
    verifica("zeraE_3", {31'd0, zeraE}, 32'd1);
  endtask

  task automatic rodada(input int r, input int erro_em, input bit parar_em_9);
    passo(4'h4);
    for (int j = 0; j <= r; j++) begin
      tem_jogada          = 1'b1;
      jogada_correta      = (j != erro_em);
      enderecoIgualRodada = (j == r);
      fimR                = (r == 15);
      passo(4'h5);
      tem_jogada = 1'b0;
      passo(4'h6);
      if (j == erro_em) begin
        passo(4'hE);
        return;
      end
      if (j < r) begin
        passo(4'h7);
        passo(4'h4);
      end else if (r == 15) begin
        passo(4'hC);
      end else begin
        passo(4'h8);
        passo(4'h9);
        if (parar_em_9) return;
        tem_jogada = 1'b1;
        passo(4'hA);
        tem_jogada = 1'b0;
        passo(4'hB);
        passo(4'h3);
      end
    end
  endtask

  initial begin
    int cont;
    reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0;
    jogada_correta = 1'b0; enderecoIgualRodada = 1'b0; fimR = 1'b0;
    tick();
    passo(4'h0);
    reset = 1'b0;
    passo(4'h0);

    // First game: reset while waiting for a play
    inicia_jogo(5);
    passo(4'h4);
    reset = 1'b1;
    passo(4'h0);
    reset = 1'b0;
    passo(4'h0);

    // Wrong play in round 2, then restart clears perdeu
    inicia_jogo(2);
    rodada(0, -1, 1'b0);
    rodada(1, -1, 1'b0);
    rodada(2, 0, 1'b0);
    passo(4'hE);

    // Idle in espera_nova during round 3
    inicia_jogo(2);
    for (int r = 0; r < 3; r++) rodada(r, -1, 1'b0);
    rodada(3, -1, 1'b1);
`ifdef TIMEOUT_EN
    cont = 1;
    for (int k = 0; k < 6000; k++) begin
      tick();
      if (db_estado == 4'h9) cont++;
      else break;
    end
    verifica("espera_ciclos", cont, 5000);
    verifica("estado_D", {28'd0, db_estado}, 32'hD);
    verifica("db_timeout_D", {31'd0, db_timeout}, 32'd1);
    verifica("perdeu_D", {31'd0, perdeu}, 32'd1);
    passo(4'hD);
`else
    cont = 0;
    for (int k = 0; k < 6000; k++) begin
      tick();
      if (db_estado == 4'h9) cont++;
    end
    verifica("espera_sem_timeout", cont, 6000);
    verifica("db_timeout_0", {31'd0, db_timeout}, 32'd0);
    verifica("perdeu_0", {31'd0, perdeu}, 32'd0);
    reset = 1'b1;
    passo(4'h0);
    reset = 1'b0;
`endif

    // Full 16-round win
    inicia_jogo(2);
    for (int r = 0; r < 16; r++) rodada(r, -1, 1'b0);
    fimR = 1'b0;
    passo(4'hC);
    verifica("ganhou_C", {31'd0, ganhou}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

endmodule
